mbank_ctrl: RTL and testbench

Single-port 32x8 memory bank with a request/busy/ready access controller. The controller accepts a one-cycle request, holds it for a programmable read or write latency, then performs the access. It signals completion with a ready pulse and busy deassertion. It sits between a simple master (CPU or bus shim) and on-chip storage, and models fixed-latency memory.

---
 rtl/mbank_pkg.sv | 18 +
 rtl/mbank_ram.sv | 28 ++
 rtl/mbank_ctrl.sv | 124 ++++++++++++
 tb/tb_mbank_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mbank_pkg.sv
// Shared widths, state encoding and operand types for the memory bank controller.
package mbank_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 32;
    localparam int CNT_W  = 4;

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [CNT_W-1:0]  cnt_t;

endpackage

// File: rtl/mbank_ram.sv
// 32x8 synchronous single-port storage with a registered read port, no reset.
module mbank_ram
    import mbank_pkg::*;
(
    input  logic  clk,
    input  logic  we,
    input  logic  re,
    input  addr_t addr,
    input  data_t din,
    output data_t dout
);

    data_t mem [DEPTH];
    data_t dout_q;

    // Write and read share the address; the read register only moves on re.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= din;
        end
        if (re) begin
            dout_q <= mem[addr];
        end
    end

    assign dout = dout_q;

endmodule

// File: rtl/mbank_ctrl.sv
// Fixed-latency access controller in front of the 32x8 bank.
//   state  | meaning
//   IDLE   | waiting for req; operands latched when req is seen
//   ACCESS | counting down latency; access performed when counter hits 0
module mbank_ctrl
    import mbank_pkg::*;
#(
    parameter int unsigned READ_LATENCY  = 2,
    parameter int unsigned WRITE_LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              ready,
    output logic              busy
);

    if (READ_LATENCY < 1 || READ_LATENCY > 15) begin : g_bad_rd_lat
        $error("mbank_ctrl: READ_LATENCY must be in 1..15");
    end
    if (WRITE_LATENCY < 1 || WRITE_LATENCY > 15) begin : g_bad_wr_lat
        $error("mbank_ctrl: WRITE_LATENCY must be in 1..15");
    end

    localparam cnt_t RD_LOAD = cnt_t'(READ_LATENCY - 1);
    localparam cnt_t WR_LOAD = cnt_t'(WRITE_LATENCY - 1);

    state_t state_q, state_d;
    cnt_t   cnt_q, cnt_d;
    logic   we_q, we_d;
    addr_t  addr_q, addr_d;
    data_t  din_q, din_d;
    logic   busy_q, busy_d;
    logic   ready_q, ready_d;
    logic   dout_vld_q, dout_vld_d;
    logic   ram_we, ram_re;
    data_t  ram_dout;

    // Next-state and strobe decode; ram strobes fire only on the final ACCESS cycle.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        addr_d     = addr_q;
        din_d      = din_q;
        busy_d     = busy_q;
        ready_d    = 1'b0;
        dout_vld_d = dout_vld_q;
        ram_we     = 1'b0;
        ram_re     = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = ACCESS;
                    we_d    = we;
                    addr_d  = addr;
                    din_d   = din;
                    cnt_d   = we ? WR_LOAD : RD_LOAD;
                    busy_d  = 1'b1;
                end
            end
            ACCESS: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - cnt_t'(1);
                end else begin
                    ram_we  = we_q;
                    ram_re  = ~we_q;
                    busy_d  = 1'b0;
                    ready_d = 1'b1;
                    state_d = IDLE;
                    if (!we_q) begin
                        dout_vld_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Controller registers; reset aborts any access in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            din_q      <= '0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b0;
            dout_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
            busy_q     <= busy_d;
            ready_q    <= ready_d;
            dout_vld_q <= dout_vld_d;
        end
    end

    mbank_ram u_ram (
        .clk  (clk),
        .we   (ram_we),
        .re   (ram_re),
        .addr (addr_q),
        .din  (din_q),
        .dout (ram_dout)
    );

    // The ram read register has no reset, so dout reads as zero until the first read lands.
    assign dout  = dout_vld_q ? ram_dout : '0;
    assign ready = ready_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_mbank_ctrl.sv
// Bench for mbank_ctrl: two instances (default latencies and 4/1) against a behavioural memory model.
module tb_mbank_ctrl;

    logic       clk;
    logic       rst;
    logic       req_a, we_a, ready_a, busy_a;
    logic [4:0] addr_a;
    logic [7:0] din_a, dout_a;
    logic       req_b, we_b, ready_b, busy_b;
    logic [4:0] addr_b;
    logic [7:0] din_b, dout_b;

    int n_cmp = 0;
    int n_err = 0;

    int rlat [2] = '{2, 4};
    int wlat [2] = '{2, 1};

    logic [7:0] mem_m   [2][32];
    bit         mem_ok  [2][32];
    logic [7:0] dout_m  [2];
    bit         dout_ok [2];

    typedef struct {
        bit         w;
        logic [4:0] a;
        logic [7:0] d;
        logic [7:0] exp;
    } vec_t;
    vec_t vecs [5];

    mbank_ctrl #(.READ_LATENCY(2), .WRITE_LATENCY(2)) u_dut_a (
        .clk(clk), .rst(rst), .req(req_a), .we(we_a), .addr(addr_a),
        .din(din_a), .dout(dout_a), .ready(ready_a), .busy(busy_a)
    );

    mbank_ctrl #(.READ_LATENCY(4), .WRITE_LATENCY(1)) u_dut_b (
        .clk(clk), .rst(rst), .req(req_b), .we(we_b), .addr(addr_b),
        .din(din_b), .dout(dout_b), .ready(ready_b), .busy(busy_b)
    );

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic set_in(input int sel, input bit r, input bit w, input logic [4:0] a, input logic [7:0] d);
        if (sel == 0) begin
            req_a = r; we_a = w; addr_a = a; din_a = d;
        end else begin
            req_b = r; we_b = w; addr_b = a; din_b = d;
        end
    endtask

    function automatic logic get_busy(input int sel);
        return (sel == 0) ? busy_a : busy_b;
    endfunction

    function automatic logic get_ready(input int sel);
        return (sel == 0) ? ready_a : ready_b;
    endfunction

    function automatic logic [7:0] get_dout(input int sel);
        return (sel == 0) ? dout_a : dout_b;
    endfunction

    // Called at a negedge; returns at the negedge of the idle cycle after completion.
    task automatic access(input int sel, input bit w, input logic [4:0] a, input logic [7:0] d);
        int nb, nr, guard;
        nb = 0; nr = 0; guard = 0;
        set_in(sel, 1'b1, w, a, d);
        @(posedge clk);
        #1;
        set_in(sel, 1'b0, w, a, d);
        forever begin
            @(negedge clk);
            if (get_ready(sel)) nr++;
            if (!get_busy(sel)) break;
            nb++;
            guard++;
            if (guard > 40) begin
                check("busy_timeout", 1, 0);
                break;
            end
        end
        if (w) begin
            mem_m[sel][a]  = d;
            mem_ok[sel][a] = 1'b1;
        end else begin
            dout_m[sel]  = mem_m[sel][a];
            dout_ok[sel] = mem_ok[sel][a];
        end
        check(w ? "busy_len_wr" : "busy_len_rd", nb, w ? wlat[sel] : rlat[sel]);
        if (dout_ok[sel]) check("dout", get_dout(sel), dout_m[sel]);
        @(negedge clk);
        if (get_ready(sel)) nr++;
        check("ready_pulses", nr, 1);
    endtask

    initial begin
        int guard;
        logic [4:0] ra;
        logic [7:0] rd;
        bit rw;

        vecs[0] = '{w: 1'b1, a: 5'd5,  d: 8'hA5, exp: 8'd31};
        vecs[1] = '{w: 1'b0, a: 5'd5,  d: 8'h00, exp: 8'hA5};
        vecs[2] = '{w: 1'b1, a: 5'd6,  d: 8'h3C, exp: 8'hA5};
        vecs[3] = '{w: 1'b0, a: 5'd6,  d: 8'h00, exp: 8'h3C};
        vecs[4] = '{w: 1'b0, a: 5'd17, d: 8'h00, exp: 8'd17};

        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 32; i++) begin
                mem_m[s][i]  = 8'h00;
                mem_ok[s][i] = 1'b0;
            end
            dout_m[s]  = 8'h00;
            dout_ok[s] = 1'b1;
        end

        rst = 1'b0;
        set_in(0, 1'b0, 1'b0, 5'd0, 8'h00);
        set_in(1, 1'b0, 1'b0, 5'd0, 8'h00);
        #15;
        check("rst_busy", busy_a, 0);
        check("rst_ready", ready_a, 0);
        check("rst_dout", dout_a, 0);
        check("rst_dout_b", dout_b, 0);
        rst = 1'b1;

        // fill and readback
        for (int a = 0; a < 32; a++) access(0, 1'b1, 5'(a), 8'(a));
        for (int a = 0; a < 32; a++) begin
            access(0, 1'b0, 5'(a), 8'h00);
            check("readback", dout_a, 32'(a));
        end

        // overwrite table
        for (int i = 0; i < 5; i++) begin
            access(0, vecs[i].w, vecs[i].a, vecs[i].d);
            check("vec_dout", dout_a, vecs[i].exp);
        end

        // req held through busy with changing operands
        set_in(0, 1'b1, 1'b1, 5'd3, 8'h11);
        @(posedge clk);
        #1;
        set_in(0, 1'b1, 1'b1, 5'd9, 8'hFF);
        @(negedge clk);
        check("hold_busy1", busy_a, 1);
        @(negedge clk);
        check("hold_busy2", busy_a, 1);
        @(negedge clk);
        check("hold_done_busy", busy_a, 0);
        check("hold_done_ready", ready_a, 1);
        @(negedge clk);
        check("hold_restart", busy_a, 1);
        set_in(0, 1'b0, 1'b1, 5'd9, 8'hFF);
        guard = 0;
        while (busy_a && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        check("hold_second_done", busy_a, 0);
        @(negedge clk);
        mem_m[0][3] = 8'h11;
        mem_m[0][9] = 8'hFF;
        access(0, 1'b0, 5'd3, 8'h00);
        check("hold_mem3", dout_a, 8'h11);
        access(0, 1'b0, 5'd9, 8'h00);
        check("hold_mem9", dout_a, 8'hFF);

        // reset one cycle into write(7, 77)
        set_in(0, 1'b1, 1'b1, 5'd7, 8'h77);
        @(posedge clk);
        #1;
        set_in(0, 1'b0, 1'b1, 5'd7, 8'h77);
        @(negedge clk);
        check("abort_busy_before", busy_a, 1);
        rst = 1'b0;
        #1;
        check("abort_busy", busy_a, 0);
        check("abort_ready", ready_a, 0);
        @(negedge clk);
        rst = 1'b1;
        dout_m[0] = 8'h00; dout_ok[0] = 1'b1;
        dout_m[1] = 8'h00; dout_ok[1] = 1'b1;
        @(negedge clk);
        access(0, 1'b0, 5'd7, 8'h00);
        check("abort_mem7", dout_a, 8'd7);

        // second instance: read latency 4, write latency 1
        access(1, 1'b1, 5'd0, 8'h5A);
        check("b_wr_dout", dout_b, 8'h00);
        access(1, 1'b0, 5'd0, 8'h00);
        check("b_rd", dout_b, 8'h5A);

        // randomized traffic on both instances
        for (int i = 0; i < 60; i++) begin
            rw = 1'($urandom_range(0, 1));
            ra = 5'($urandom_range(0, 31));
            rd = 8'($urandom);
            access(0, rw, ra, rd);
        end
        for (int i = 0; i < 40; i++) begin
            rw = 1'($urandom_range(0, 1));
            ra = 5'($urandom_range(0, 7));
            rd = 8'($urandom);
            access(1, rw, ra, rd);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
